// File: rtl/lc4_insn_queue.sv
// lc4_insn_queue: 4-entry circular instruction queue for the LC4 out-of-order core.
// Takes in-order dispatch, records per-slot issue/commit events and retires the
// oldest committed entry in order, at most one per cycle.
//
// Ports:
//   clk, rst                  clock (rising edge) and synchronous active-high reset
//   gwe                       global write enable; every register holds when low
//   flush                     discard all entries; same-cycle dispatch is dropped
//   disp_valid/insn/pc        dispatch request and payload
//   disp_ready                queue can accept a dispatch this cycle
//   issue_en/issue_idx        mark a valid slot as issued
//   commit_en/commit_idx      mark a valid, issued slot as committed
//   retire_valid/insn/pc      head slot is valid and committed; head contents
//   iq0_insn..iq3_insn        stored instruction per slot
//   iq_valid/iq_issue/iq_commit  per-slot status bits (bit n = slot n)
//   iq_rd, iq_wr, iq_count    head index, tail index, occupancy 0..4
//
// Optional feature: define LC4_IQ_RETIRE_BYPASS_EN to let a full queue accept a
// dispatch into the slot freed by a same-cycle retire.
module lc4_insn_queue #(
  parameter int unsigned INSN_W = 16,
  parameter int unsigned PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              gwe,
  input  logic              flush,
  input  logic              disp_valid,
  input  logic [INSN_W-1:0] disp_insn,
  input  logic [PC_W-1:0]   disp_pc,
  output logic              disp_ready,
  input  logic              issue_en,
  input  logic [1:0]        issue_idx,
  input  logic              commit_en,
  input  logic [1:0]        commit_idx,
  output logic              retire_valid,
  output logic [INSN_W-1:0] retire_insn,
  output logic [PC_W-1:0]   retire_pc,
  output logic [INSN_W-1:0] iq0_insn,
  output logic [INSN_W-1:0] iq1_insn,
  output logic [INSN_W-1:0] iq2_insn,
  output logic [INSN_W-1:0] iq3_insn,
  output logic [3:0]        iq_valid,
  output logic [3:0]        iq_issue,
  output logic [3:0]        iq_commit,
  output logic [1:0]        iq_rd,
  output logic [1:0]        iq_wr,
  output logic [2:0]        iq_count
);

  localparam int unsigned DEPTH = 4;

  logic [INSN_W-1:0] insn_q [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [3:0]        valid_q, issue_q, commit_q;
  logic [3:0]        valid_n, issue_n, commit_n;
  logic [1:0]        rd_q, wr_q;
  logic [2:0]        count_q;
  logic              full, retire, do_disp, issue_ok, commit_ok;

  // Head retire and dispatch acceptance
  assign full    = (count_q == 3'd4);
  assign retire  = valid_q[rd_q] & commit_q[rd_q];
`ifdef LC4_IQ_RETIRE_BYPASS_EN
  assign disp_ready = ~full | retire;
`else
  assign disp_ready = ~full;
`endif
  assign do_disp = disp_valid & disp_ready;

  // Events aimed at the retiring slot are dropped so they cannot leak into a
  // slot that is being freed (or refilled by a bypass dispatch).
  assign issue_ok  = issue_en & valid_q[issue_idx] & ~(retire & (issue_idx == rd_q));
  assign commit_ok = commit_en & valid_q[commit_idx] & ~(retire & (commit_idx == rd_q)) &
                     (issue_q[commit_idx] | (issue_ok & (issue_idx == commit_idx)));

  // Next status bits: set events, then retire clear, then dispatch fill last
  always_comb begin
    valid_n  = valid_q;
    issue_n  = issue_q;
    commit_n = commit_q;
    if (issue_ok)  issue_n[issue_idx]   = 1'b1;
    if (commit_ok) commit_n[commit_idx] = 1'b1;
    if (retire) begin
      valid_n[rd_q]  = 1'b0;
      issue_n[rd_q]  = 1'b0;
      commit_n[rd_q] = 1'b0;
    end
    if (do_disp) begin
      valid_n[wr_q]  = 1'b1;
      issue_n[wr_q]  = 1'b0;
      commit_n[wr_q] = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 4'b0;
      issue_q  <= 4'b0;
      commit_q <= 4'b0;
      rd_q     <= 2'd0;
      wr_q     <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        insn_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (gwe) begin
      if (flush) begin
        valid_q  <= 4'b0;
        issue_q  <= 4'b0;
        commit_q <= 4'b0;
        rd_q     <= 2'd0;
        wr_q     <= 2'd0;
        count_q  <= 3'd0;
      end else begin
        valid_q  <= valid_n;
        issue_q  <= issue_n;
        commit_q <= commit_n;
        rd_q     <= rd_q + 2'(retire);
        wr_q     <= wr_q + 2'(do_disp);
        count_q  <= count_q + 3'(do_disp) - 3'(retire);
        if (do_disp) begin
          insn_q[wr_q] <= disp_insn;
          pc_q[wr_q]   <= disp_pc;
        end
      end
    end
  end

  assign retire_valid = retire;
  assign retire_insn  = insn_q[rd_q];
  assign retire_pc    = pc_q[rd_q];
  assign iq0_insn     = insn_q[0];
  assign iq1_insn     = insn_q[1];
  assign iq2_insn     = insn_q[2];
  assign iq3_insn     = insn_q[3];
  assign iq_valid     = valid_q;
  assign iq_issue     = issue_q;
  assign iq_commit    = commit_q;
  assign iq_rd        = rd_q;
  assign iq_wr        = wr_q;
  assign iq_count     = count_q;

endmodule

// File: tb/tb_lc4_insn_queue.sv
// Directed bench for lc4_insn_queue. Dispatches push the expected retire payload
// into a scoreboard; an independent monitor pops it whenever the DUT retires.
module tb_lc4_insn_queue;

  logic        clk = 1'b0;
  logic        rst, gwe, flush, disp_valid, issue_en, commit_en;
  logic [15:0] disp_insn, disp_pc;
  logic [1:0]  issue_idx, commit_idx;
  logic        disp_ready, retire_valid;
  logic [15:0] retire_insn, retire_pc;
  logic [15:0] iq0_insn, iq1_insn, iq2_insn, iq3_insn;
  logic [3:0]  iq_valid, iq_issue, iq_commit;
  logic [1:0]  iq_rd, iq_wr;
  logic [2:0]  iq_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_retired = 0;
  logic [31:0] exp_q [$];

`ifdef LC4_IQ_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  lc4_insn_queue dut (
    .clk(clk), .rst(rst), .gwe(gwe), .flush(flush),
    .disp_valid(disp_valid), .disp_insn(disp_insn), .disp_pc(disp_pc),
    .disp_ready(disp_ready),
    .issue_en(issue_en), .issue_idx(issue_idx),
    .commit_en(commit_en), .commit_idx(commit_idx),
    .retire_valid(retire_valid), .retire_insn(retire_insn), .retire_pc(retire_pc),
    .iq0_insn(iq0_insn), .iq1_insn(iq1_insn), .iq2_insn(iq2_insn), .iq3_insn(iq3_insn),
    .iq_valid(iq_valid), .iq_issue(iq_issue), .iq_commit(iq_commit),
    .iq_rd(iq_rd), .iq_wr(iq_wr), .iq_count(iq_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a retire happens on any edge where the head is retirable and no
  // reset/flush/gwe hold intervenes; compare it against the oldest dispatch.
  always @(negedge clk) begin
    if (!rst && gwe && !flush && retire_valid) begin
      n_retired++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: got insn 0x%0h pc 0x%0h, none expected",
                 retire_insn, retire_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({retire_insn, retire_pc} !== e) begin
          n_fail++;
          $display("FAIL retire_payload: got 0x%0h expected 0x%0h", {retire_insn, retire_pc}, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    flush = 1'b0; disp_valid = 1'b0; disp_insn = 16'h0; disp_pc = 16'h0;
    issue_en = 1'b0; issue_idx = 2'd0; commit_en = 1'b0; commit_idx = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Dispatch one instruction; acc is whether the queue is expected to take it.
  task automatic disp(input logic [15:0] insn, input logic [15:0] pc, input bit acc);
    chk("disp_ready", 32'(disp_ready), 32'(acc));
    disp_valid = 1'b1; disp_insn = insn; disp_pc = pc;
    if (acc) exp_q.push_back({insn, pc});
    tick();
  endtask

  // Issue and commit the same slot in one cycle.
  task automatic ic(input logic [1:0] idx);
    issue_en = 1'b1; issue_idx = idx; commit_en = 1'b1; commit_idx = idx;
    tick();
  endtask

  task automatic chk_state(input string tag, input logic [3:0] v, input logic [1:0] rd,
                           input logic [1:0] wr, input logic [2:0] cnt);
    chk({tag, "_valid"}, 32'(iq_valid), 32'(v));
    chk({tag, "_rd"},    32'(iq_rd),    32'(rd));
    chk({tag, "_wr"},    32'(iq_wr),    32'(wr));
    chk({tag, "_count"}, 32'(iq_count), 32'(cnt));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1; gwe = 1'b0;
    tick();
    rst = 1'b0; gwe = 1'b1;
    tick();

    // 1. reset state
    chk_state("rst", 4'b0000, 2'd0, 2'd0, 3'd0);
    chk("rst_ready", 32'(disp_ready), 32'd1);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_iq0", 32'(iq0_insn), 32'h0);

    // 2. fill, then a held 5th dispatch
    for (int i = 0; i < 4; i++) disp(16'h1001 + 16'(i), 16'h0100 + 16'(i), 1'b1);
    chk_state("full", 4'b1111, 2'd0, 2'd0, 3'd4);
    disp(16'h1005, 16'h0104, 1'b0);
    chk_state("held", 4'b1111, 2'd0, 2'd0, 3'd4);
    chk("held_iq0", 32'(iq0_insn), 32'h1001);
    chk("held_iq3", 32'(iq3_insn), 32'h1004);

    // 3. out-of-order commit waits for head
    commit_en = 1'b1; commit_idx = 2'd2;   // not issued: ignored
    tick();
    chk("unissued_commit", 32'(iq_commit), 32'h0);
    issue_en = 1'b1; issue_idx = 2'd1;
    tick();
    commit_en = 1'b1; commit_idx = 2'd1;
    tick();
    chk("iss1", 32'(iq_issue), 32'b0010);
    chk("com1", 32'(iq_commit), 32'b0010);
    chk("head_blocks", 32'(retire_valid), 32'd0);
    ic(2'd0);
    chk("com01", 32'(iq_commit), 32'b0011);
    chk("head_ready", 32'(retire_valid), 32'd1);
    chk("head_insn", 32'(retire_insn), 32'h1001);
    tick();                               // slot0 retires
    chk_state("ret0", 4'b1110, 2'd1, 2'd0, 3'd3);
    chk("ret0_next", 32'(retire_valid), 32'd1);
    tick();                               // slot1 retires
    chk_state("ret1", 4'b1100, 2'd2, 2'd0, 3'd2);
    chk("ret1_next", 32'(retire_valid), 32'd0);
    ic(2'd2);
    ic(2'd3);                             // slot2 retires here
    tick();                               // slot3 retires
    chk_state("drain", 4'b0000, 2'd0, 2'd0, 3'd0);

    // move pointers to 3
    for (int i = 0; i < 3; i++) disp(16'h2001 + 16'(i), 16'h0200 + 16'(i), 1'b1);
    ic(2'd0);
    ic(2'd1);
    ic(2'd2);
    tick();
    chk_state("at3", 4'b0000, 2'd3, 2'd3, 3'd0);
    issue_en = 1'b1; issue_idx = 2'd3;    // invalid slot: ignored
    tick();
    chk("issue_invalid", 32'(iq_issue), 32'h0);

    // 4. wrap
    disp(16'h3001, 16'h0300, 1'b1);
    disp(16'h3002, 16'h0301, 1'b1);
    chk_state("wrap", 4'b1001, 2'd3, 2'd1, 3'd2);
    chk("wrap_iq3", 32'(iq3_insn), 32'h3001);
    chk("wrap_iq0", 32'(iq0_insn), 32'h3002);
    ic(2'd3);
    ic(2'd0);
    tick();
    chk_state("wrap_ret", 4'b0000, 2'd1, 2'd1, 3'd0);

    // 5. full queue with committed head and pending dispatch
    for (int i = 0; i < 4; i++) disp(16'h4001 + 16'(i), 16'h0400 + 16'(i), 1'b1);
    ic(2'd1);
    chk("full_head", 32'(retire_valid), 32'd1);
    disp(16'h4005, 16'h0404, BYP);
    if (BYP) begin
      chk_state("bypass", 4'b1111, 2'd2, 2'd2, 3'd4);
      chk("bypass_iq1", 32'(iq1_insn), 32'h4005);
    end else begin
      chk_state("nobypass", 4'b1101, 2'd2, 2'd1, 3'd3);
      disp(16'h4005, 16'h0404, 1'b1);
      chk_state("nobypass2", 4'b1111, 2'd2, 2'd2, 3'd4);
    end

    // 6. flush with 3 entries plus dispatch
    ic(2'd2);
    tick();
    chk("pre_flush_count", 32'(iq_count), 32'd3);
    flush = 1'b1; disp_valid = 1'b1; disp_insn = 16'h5555; disp_pc = 16'h0555;
    exp_q.delete();
    tick();
    chk_state("flush", 4'b0000, 2'd0, 2'd0, 3'd0);
    chk("flush_issue", 32'(iq_issue), 32'h0);
    disp(16'h5000, 16'h0500, 1'b1);
    gwe = 1'b0;
    disp_valid = 1'b1; disp_insn = 16'h5001; disp_pc = 16'h0501;
    issue_en = 1'b1; issue_idx = 2'd0; commit_en = 1'b1; commit_idx = 2'd0;
    tick();
    gwe = 1'b1;
    chk_state("gwe0", 4'b0001, 2'd0, 2'd1, 3'd1);
    chk("gwe0_issue", 32'(iq_issue), 32'h0);
    chk("gwe0_iq1", 32'(iq1_insn), 32'h4005);

    // reset mid-operation
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    chk_state("rst2", 4'b0000, 2'd0, 2'd0, 3'd0);
    chk("rst2_iq0", 32'(iq0_insn), 32'h0);
    chk("rst2_iq1", 32'(iq1_insn), 32'h0);

    chk("retire_total", 32'(n_retired), 32'd11);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
